prd_com_filter: RTL and testbench

PRD_COM_FILTER -- requirements
Module: prd_com_filter

---
 rtl/prd_com_filter.sv | 109 ++++++++++
 tb/tb_prd_com_filter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/prd_com_filter.sv
// prd_com_filter: per-channel glitch filter for optocoupler command inputs.
// Each channel has a two-flop synchronizer and a restart-on-agree counter.
// The synchronized level must differ from the output for FILTER_LEN edges
// before the output follows it. iBl == 0 forces all outputs inactive.
// Optional feature: define PRD_COM_IRQ_EN to add iAck/oIrq, a latched change
// interrupt.

module prd_com_filter_ch #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic iRes,
  input  logic iRaw,
  input  logic iBl,
  output logic oCom,
  output logic comNext
);
  localparam logic [7:0] LAST = 8'(FILTER_LEN - 1);

  logic       s1, s2;
  logic [7:0] cnt, cntNext;

  // Two-flop synchronizer; keeps running while blocked.
  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= iRaw;
      s2 <= s1;
    end
  end

  // Next-state rule: block, restart when the input agrees, count, or commit.
  always_comb begin
    cntNext = cnt;
    comNext = oCom;
    if (!iBl) begin
      cntNext = '0;
      comNext = 1'b0;
    end else if (s2 == oCom) begin
      cntNext = '0;
    end else if (cnt == LAST) begin
      cntNext = '0;
      comNext = s2;
    end else begin
      cntNext = cnt + 8'd1;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) begin
      cnt  <= '0;
      oCom <= 1'b0;
    end else begin
      cnt  <= cntNext;
      oCom <= comNext;
    end
  end
endmodule

module prd_com_filter #(
  parameter int FILTER_LEN = 8,
  parameter int WIDTH      = 16
) (
  input  logic             clk,
  input  logic             iRes,
  input  logic [WIDTH-1:0] iComRaw,
  input  logic             iBl,
  output logic [WIDTH-1:0] oCom,
  output logic             oChange
`ifdef PRD_COM_IRQ_EN
  ,
  input  logic             iAck,
  output logic             oIrq
`endif
);
  logic [WIDTH-1:0] comNext;
  logic             chg;

  // One independent filter lane per command channel.
  for (genvar i = 0; i < WIDTH; i++) begin : gLane
    prd_com_filter_ch #(.FILTER_LEN(FILTER_LEN)) uCh (
      .clk    (clk),
      .iRes   (iRes),
      .iRaw   (iComRaw[i]),
      .iBl    (iBl),
      .oCom   (oCom[i]),
      .comNext(comNext[i])
    );
  end

  assign chg = |(comNext ^ oCom);

  // Change pulse is registered on the same edge the output moves.
  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) oChange <= 1'b0;
    else       oChange <= chg;
  end

`ifdef PRD_COM_IRQ_EN
  // Interrupt latch: a new change wins over a coincident acknowledge.
  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) oIrq <= 1'b0;
    else       oIrq <= chg | (oIrq & ~iAck);
  end
`endif
endmodule

// File: tb/tb_prd_com_filter.sv
// Bench for prd_com_filter: directed scenarios plus random traffic, checked
// against a sliding-window model of the filtering rule.
module tb_prd_com_filter;
  localparam int FL = 8;
  localparam int W  = 16;

  logic         clk = 1'b0;
  logic         iRes = 1'b0;
  logic         iBl = 1'b1;
  logic [W-1:0] iComRaw = '0;
  logic [W-1:0] oCom;
  logic         oChange;
`ifdef PRD_COM_IRQ_EN
  logic         iAck = 1'b0;
  logic         oIrq;
  logic         mIrq = 1'b0;
`endif

  always #5 clk = ~clk;

  prd_com_filter #(.FILTER_LEN(FL), .WIDTH(W)) dut (
    .clk    (clk),
    .iRes   (iRes),
    .iComRaw(iComRaw),
    .iBl    (iBl),
    .oCom   (oCom),
    .oChange(oChange)
`ifdef PRD_COM_IRQ_EN
    ,
    .iAck   (iAck),
    .oIrq   (oIrq)
`endif
  );

  int           total = 0;
  int           bad = 0;
  int           edgeN = 0;
  int           resetEdge = 0;
  logic [W-1:0] rawHist [0:4095];
  int           lastEv [W];
  logic [W-1:0] mCom = '0;
  logic         mChg = 1'b0;

  // Synchronized level seen by the filter at edge m (raw from two edges before).
  function automatic logic sAt(int m, int i);
    if (m - 2 <= resetEdge) return 1'b0;
    return rawHist[m-2][i];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: model update, then compare outputs.
  task automatic tick();
    logic [W-1:0] prev;
    logic         blk;
`ifdef PRD_COM_IRQ_EN
    logic         ack;
    ack = iAck;
`endif
    if (edgeN >= 4090) begin
      $display("FAIL edge_budget observed=%0d expected<4090", edgeN);
      $fatal(1, "edge budget exceeded");
    end
    rawHist[edgeN+1] = iComRaw;
    blk = ~iBl;
    @(posedge clk);
    edgeN++;
    prev = mCom;
    if (blk) begin
      mCom = '0;
      for (int i = 0; i < W; i++) lastEv[i] = edgeN;
    end else begin
      for (int i = 0; i < W; i++) begin
        bit ok;
        ok = 1'b1;
        // Output flips only after FL consecutive disagreeing edges with no
        // intervening commit, block or reset.
        for (int j = 0; j < FL; j++) begin
          if (edgeN - j <= lastEv[i] || sAt(edgeN - j, i) == mCom[i]) ok = 1'b0;
        end
        if (ok) begin
          mCom[i]   = ~mCom[i];
          lastEv[i] = edgeN;
        end
      end
    end
    mChg = (prev != mCom);
`ifdef PRD_COM_IRQ_EN
    mIrq = mChg | (mIrq & ~ack);
`endif
    #1;
    check("oCom", oCom, mCom);
    check("oChange", {{(W-1){1'b0}}, oChange}, {{(W-1){1'b0}}, mChg});
`ifdef PRD_COM_IRQ_EN
    check("oIrq", {{(W-1){1'b0}}, oIrq}, {{(W-1){1'b0}}, mIrq});
`endif
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic doReset();
    #1 iRes = 1'b0;
    #1;
    check("rst_oCom", oCom, '0);
    check("rst_oChange", {{(W-1){1'b0}}, oChange}, '0);
`ifdef PRD_COM_IRQ_EN
    check("rst_oIrq", {{(W-1){1'b0}}, oIrq}, '0);
    mIrq = 1'b0;
`endif
    resetEdge = edgeN;
    mCom = '0;
    for (int i = 0; i < W; i++) lastEv[i] = edgeN;
    iRes = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < W; i++) lastEv[i] = 0;
    // Reset with all raw inputs high: outputs clear with no clock edge.
    iComRaw = 16'hFFFF;
    #3;
    check("init_oCom", oCom, 16'h0000);
    check("init_oChange", {{(W-1){1'b0}}, oChange}, '0);
    iRes = 1'b1;
    // Inputs already high appear after FL+2 edges following release.
    ticks(FL + 1);
    check("rel_before", oCom, 16'h0000);
    tick();
    check("rel_after", oCom, 16'hFFFF);
    iComRaw = 16'h0000;
    ticks(12);

    // Latency: 0 through edge k+8, 1331 after edge k+9.
    iComRaw = 16'h1331;
    ticks(FL + 1);
    check("lat_before", oCom, 16'h0000);
    tick();
    check("lat_after", oCom, 16'h1331);
    check("lat_pulse", {{(W-1){1'b0}}, oChange}, 16'h0001);
    tick();
    check("lat_pulse_end", {{(W-1){1'b0}}, oChange}, 16'h0000);
    iComRaw = 16'h0000;
    ticks(12);

    // Glitch: 7 cycles rejected, 8 cycles accepted.
    iComRaw = 16'h0001; ticks(FL - 1);
    iComRaw = 16'h0000; ticks(12);
    check("glitch7", oCom, 16'h0000);
    iComRaw = 16'h0001; ticks(FL);
    iComRaw = 16'h0000; ticks(2);
    check("glitch8", oCom, 16'h0001);
    ticks(12);

    // Restart: 5 high, 1 low, then high again needs 8 fresh cycles.
    iComRaw = 16'h0008; ticks(5);
    iComRaw = 16'h0000; tick();
    iComRaw = 16'h0008; ticks(FL + 1);
    check("restart_hold", oCom, 16'h0000);
    tick();
    check("restart_rise", oCom, 16'h0008);
    iComRaw = 16'h0000; ticks(12);

    // Block and release.
    iComRaw = 16'h7384; ticks(12);
    check("blk_pre", oCom, 16'h7384);
    iBl = 1'b0; tick();
    check("blk_clear", oCom, 16'h0000);
    check("blk_pulse", {{(W-1){1'b0}}, oChange}, 16'h0001);
    iBl = 1'b1; ticks(FL - 1);
    check("blk_wait", oCom, 16'h0000);
    tick();
    check("blk_back", oCom, 16'h7384);

    // Reset in mid-filtering restarts everything.
    iComRaw = 16'h00F0; ticks(4);
    doReset();
    ticks(14);

    // Random traffic with occasional block, ack and reset.
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] flip;
      flip = '0;
      for (int i = 0; i < W; i++) flip[i] = ($urandom_range(0, 6) == 0);
      iComRaw = iComRaw ^ flip;
      iBl = ($urandom_range(0, 40) != 0);
`ifdef PRD_COM_IRQ_EN
      iAck = ($urandom_range(0, 3) == 0);
`endif
      if (n == 200) doReset();
      tick();
    end
    iBl = 1'b1;
    iComRaw = 16'hA5A5;
    ticks(FL + 4);
    check("final", oCom, 16'hA5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
